// File: rtl/score_digit_scheduler.sv
// Score-digit overlay controller: serial double-dabble conversion of binary
// scores, committed to the display register only during vertical blanking.
module score_digit_scheduler #(
  parameter int score_width_p = 16,
  parameter int digits_p      = 5,
  parameter int sel_width_p   = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [score_width_p-1:0] score_i,
  input  logic                     score_v_i,
  output logic                     ready_o,
  input  logic                     vblank_i,
  input  logic [sel_width_p-1:0]   digit_sel_i,
  output logic [3:0]               digit_o,
  output logic [digits_p-1:0]      blank_mask_o,
  output logic                     busy_o,
  output logic                     commit_o
);

  localparam int SW = score_width_p;
  localparam int BW = 4 * digits_p;
  localparam int CW = $clog2(SW + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;

  localparam logic [digits_p-1:0] MASK_RST =
    {1'b0, {(digits_p-1){1'b1}}};

  logic [1:0]          r_state;
  logic [SW-1:0]       r_shift;
  logic [BW-1:0]       r_scratch;
  logic [CW-1:0]       r_cnt;
  logic [BW-1:0]       r_disp;
  logic [digits_p-1:0] r_mask;
  logic                r_commit;

  logic [BW-1:0]       w_adj;
  logic [digits_p-1:0] w_mask;
  logic                w_zero;
  logic [3:0]          w_digit;

  always_comb begin
    w_adj = '0;
    for (int i = 0; i < digits_p; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      else
        w_adj[4*i +: 4] = r_scratch[4*i +: 4];
    end
  end

  // Column 0 lives in the most significant nibble.
  always_comb begin
    w_mask = '0;
    w_zero = 1'b1;
    for (int i = 0; i < digits_p; i++) begin
      w_zero = w_zero & (r_scratch[4*(digits_p-1-i) +: 4] == 4'd0);
      w_mask[i] = w_zero & (i != digits_p - 1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_disp    <= '0;
      r_mask    <= MASK_RST;
      r_commit  <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (score_v_i) begin
            r_shift   <= score_i;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_state   <= CONVERT;
          end
        end
        CONVERT: begin
          r_scratch <= {w_adj[BW-2:0], r_shift[SW-1]};
          r_shift   <= {r_shift[SW-2:0], 1'b0};
          r_cnt     <= r_cnt + CW'(1);
          if (r_cnt == CW'(SW - 1))
            r_state <= WAIT;
        end
        WAIT: begin
          if (vblank_i) begin
            r_disp   <= r_scratch;
            r_mask   <= w_mask;
            r_commit <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_digit = 4'hF;
    for (int i = 0; i < digits_p; i++) begin
      if (digit_sel_i == sel_width_p'(i) && !r_mask[i])
        w_digit = r_disp[4*(digits_p-1-i) +: 4];
    end
  end

  assign ready_o      = (r_state == IDLE);
  assign busy_o       = (r_state != IDLE);
  assign commit_o     = r_commit;
  assign blank_mask_o = r_mask;
  assign digit_o      = w_digit;

endmodule

// File: tb/tb_score_digit_scheduler.sv
// Directed bench for score_digit_scheduler: handshake timing, vblank-gated
// commit, leading-zero blanking, back-to-back transfers and async reset.
module tb_score_digit_scheduler;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] score_i;
  logic        score_v_i;
  logic        ready_o;
  logic        vblank_i;
  logic [2:0]  digit_sel_i;
  logic [3:0]  digit_o;
  logic [4:0]  blank_mask_o;
  logic        busy_o;
  logic        commit_o;

  int n_tests = 0;
  int n_fail  = 0;

  score_digit_scheduler dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .score_i      (score_i),
    .score_v_i    (score_v_i),
    .ready_o      (ready_o),
    .vblank_i     (vblank_i),
    .digit_sel_i  (digit_sel_i),
    .digit_o      (digit_o),
    .blank_mask_o (blank_mask_o),
    .busy_o       (busy_o),
    .commit_o     (commit_o)
  );

  always #10 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reads columns 0..4; takes 5 ns, always started at a falling edge.
  task automatic chk_digits(input string tag, input logic [19:0] exp);
    for (int s = 0; s < 5; s++) begin
      digit_sel_i = 3'(s);
      #1;
      chk($sformatf("%s col%0d", tag, s), 16'(digit_o),
          16'(exp[4*(4-s) +: 4]));
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic chk_ctl(input string tag, input logic rdy,
                         input logic bsy, input logic cmt);
    chk({tag, " ready"},  16'(ready_o),  16'(rdy));
    chk({tag, " busy"},   16'(busy_o),   16'(bsy));
    chk({tag, " commit"}, 16'(commit_o), 16'(cmt));
  endtask

  initial begin
    reset_i     = 1'b1;
    score_i     = '0;
    score_v_i   = 1'b0;
    vblank_i    = 1'b0;
    digit_sel_i = '0;
    tick();
    tick();
    reset_i = 1'b0;
    tick();

    // Reset state
    chk_ctl("rst", 1'b1, 1'b0, 1'b0);
    chk("rst mask", 16'(blank_mask_o), 16'h000F);
    chk_digits("rst", 20'hFFFF0);
    for (int s = 5; s < 8; s++) begin
      digit_sel_i = 3'(s);
      #1;
      chk($sformatf("rst sel%0d", s), 16'(digit_o), 16'hF);
    end

    // 12345 with vblank held high: commit in T+18
    tick();
    vblank_i  = 1'b1;
    score_i   = 16'd12345;
    score_v_i = 1'b1;
    tick();
    score_v_i = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      chk($sformatf("t2 ready T+%0d", k), 16'(ready_o), 16'd0);
      chk($sformatf("t2 commit T+%0d", k), 16'(commit_o), 16'd0);
      tick();
    end
    chk_ctl("t2 T+18", 1'b1, 1'b0, 1'b1);
    chk("t2 mask", 16'(blank_mask_o), 16'h0000);
    chk_digits("t2", 20'h12345);
    tick();
    chk("t2 commit T+19", 16'(commit_o), 16'd0);

    // 907 with vblank low until T+40
    vblank_i  = 1'b0;
    score_i   = 16'd907;
    score_v_i = 1'b1;
    tick();
    score_v_i = 1'b0;
    for (int k = 1; k < 40; k++) begin
      if (k % 8 == 0)
        chk($sformatf("t3 busy T+%0d", k), 16'(busy_o), 16'd1);
      chk($sformatf("t3 commit T+%0d", k), 16'(commit_o), 16'd0);
      tick();
    end
    vblank_i = 1'b1;
    chk_ctl("t3 T+40", 1'b0, 1'b1, 1'b0);
    chk_digits("t3 old", 20'h12345);
    tick();
    chk_ctl("t3 T+41", 1'b1, 1'b0, 1'b1);
    chk("t3 mask", 16'(blank_mask_o), 16'h0003);
    chk_digits("t3", 20'hFF907);

    // 65535 then 0 issued the cycle ready returns
    tick();
    score_i   = 16'd65535;
    score_v_i = 1'b1;
    tick();
    score_v_i = 1'b0;
    for (int k = 1; k < 18; k++) tick();
    chk_ctl("t4a", 1'b1, 1'b0, 1'b1);
    chk_digits("t4a", 20'h65535);
    score_i   = 16'd0;
    score_v_i = 1'b1;
    tick();
    score_v_i = 1'b0;
    chk_ctl("t4b T+1", 1'b0, 1'b1, 1'b0);
    for (int k = 1; k < 18; k++) tick();
    chk_ctl("t4b", 1'b1, 1'b0, 1'b1);
    chk("t4b mask", 16'(blank_mask_o), 16'h000F);
    chk_digits("t4b", 20'hFFFF0);

    // valid held high; score_i changes during CONVERT
    tick();
    score_i   = 16'd100;
    score_v_i = 1'b1;
    tick();
    tick();
    tick();
    score_i = 16'd999;
    for (int k = 3; k < 18; k++) tick();
    chk_ctl("t5a", 1'b1, 1'b0, 1'b1);
    chk_digits("t5a", 20'hFF100);
    tick();
    chk_ctl("t5b T+1", 1'b0, 1'b1, 1'b0);
    score_v_i = 1'b0;
    for (int k = 1; k < 18; k++) tick();
    chk_ctl("t5b", 1'b1, 1'b0, 1'b1);
    chk_digits("t5b", 20'hFF999);
    tick();
    chk_ctl("t5 idle", 1'b1, 1'b0, 1'b0);

    // async reset mid-CONVERT
    score_i   = 16'd4321;
    score_v_i = 1'b1;
    tick();
    score_v_i = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    reset_i = 1'b1;
    #1;
    chk_ctl("t6 rst", 1'b1, 1'b0, 1'b0);
    chk("t6 mask", 16'(blank_mask_o), 16'h000F);
    chk_digits("t6 rst", 20'hFFFF0);
    reset_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("t6 nocommit %0d", k), 16'(commit_o), 16'd0);
    end
    chk("t6 busy", 16'(busy_o), 16'd0);
    score_i   = 16'd42;
    score_v_i = 1'b1;
    tick();
    score_v_i = 1'b0;
    for (int k = 1; k < 18; k++) tick();
    chk_ctl("t6 42", 1'b1, 1'b0, 1'b1);
    chk_digits("t6 42", 20'hFFF42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
